// File: rtl/instr_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | instr_sequencer: expands fetched words into the per-slot 5-bit opcode  |
// | stream (two-part pairs, LDM immediates, interrupt entry, bubbles).     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module instr_sequencer #(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_valid,
  input  logic [IW-1:0] fetch_word,
  output logic          fetch_ready,
  input  logic          stall,
  input  logic          flush,
  input  logic          int_req,
  output logic [4:0]    op_code,
  output logic          op_valid,
  output logic          op_bubble,
  output logic          imm_valid,
  output logic [IW-1:0] imm_data,
  output logic          int_ack
);

  localparam logic [2:0] c_stIssue  = 3'd0;
  localparam logic [2:0] c_stSecond = 3'd1;
  localparam logic [2:0] c_stImm    = 3'd2;
  localparam logic [2:0] c_stInt1   = 3'd3;
  localparam logic [2:0] c_stInt2   = 3'd4;

  localparam logic [4:0] c_opNop  = 5'b00000;
  localparam logic [4:0] c_opLdm  = 5'b10001;
  localparam logic [4:0] c_opCall = 5'b11000;
  localparam logic [4:0] c_opRet  = 5'b11010;
  localparam logic [4:0] c_opRti  = 5'b11100;
  localparam logic [4:0] c_opIntA = 5'b11110;
  localparam logic [4:0] c_opIntB = 5'b11111;

  logic [2:0]    r_state;
  logic [2:0]    w_stateNext;
  logic          r_intPend;
  logic          w_intPendNext;
  logic [4:0]    r_secondOp;
  logic [4:0]    w_secondOpNext;
  logic [4:0]    r_opCode;
  logic [4:0]    w_opCodeNext;
  logic          r_opValid;
  logic          w_opValidNext;
  logic          r_opBubble;
  logic          w_opBubbleNext;
  logic          r_immValid;
  logic          w_immValidNext;
  logic [IW-1:0] r_immData;
  logic [IW-1:0] w_immDataNext;
  logic          r_intAck;
  logic          w_intAckNext;

  logic [4:0]    w_fetchOp;
  logic          w_isPair;
  logic          w_flushSeq;
  logic          w_issueFree;

  assign w_fetchOp   = fetch_word[IW-1:IW-5];
  assign w_isPair    = (w_fetchOp == c_opCall) || (w_fetchOp == c_opRet) ||
                       (w_fetchOp == c_opRti);
  // The interrupt sequence is never split, so flush only acts outside INT1/INT2.
  assign w_flushSeq  = flush && (r_state != c_stInt1) && (r_state != c_stInt2);
  assign w_issueFree = (r_state == c_stIssue) && !r_intPend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_stIssue;
      r_intPend  <= 1'b0;
      r_secondOp <= c_opNop;
      r_opCode   <= c_opNop;
      r_opValid  <= 1'b0;
      r_opBubble <= 1'b0;
      r_immValid <= 1'b0;
      r_immData  <= '0;
      r_intAck   <= 1'b0;
    end else begin
      r_intPend <= w_intPendNext;
      if (!stall) begin
        r_state    <= w_stateNext;
        r_secondOp <= w_secondOpNext;
        r_opCode   <= w_opCodeNext;
        r_opValid  <= w_opValidNext;
        r_opBubble <= w_opBubbleNext;
        r_immValid <= w_immValidNext;
        r_immData  <= w_immDataNext;
        r_intAck   <= w_intAckNext;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_flushSeq) begin
      w_stateNext = c_stIssue;
    end else begin
      case (r_state)
        c_stIssue: begin
          if (r_intPend) begin
            w_stateNext = c_stInt1;
          end else if (fetch_valid) begin
            if (w_isPair) begin
              w_stateNext = c_stSecond;
            end else if (w_fetchOp == c_opLdm) begin
              w_stateNext = c_stImm;
            end
          end
        end
        c_stSecond: w_stateNext = c_stIssue;
        c_stImm:    w_stateNext = fetch_valid ? c_stIssue : c_stImm;
        c_stInt1:   w_stateNext = c_stInt2;
        c_stInt2:   w_stateNext = c_stIssue;
        default:    w_stateNext = c_stIssue;
      endcase
    end
  end

  always_comb begin
    fetch_ready    = !stall && !w_flushSeq && (w_issueFree || (r_state == c_stImm));
    w_opCodeNext   = c_opNop;
    w_opValidNext  = 1'b0;
    w_opBubbleNext = 1'b0;
    w_immValidNext = 1'b0;
    w_immDataNext  = r_immData;
    w_intAckNext   = 1'b0;
    w_secondOpNext = r_secondOp;
    // A request arriving while 11111 issues keeps the pending flag alive.
    w_intPendNext  = int_req || (r_intPend && !(r_state == c_stInt1 && !stall));
    if (w_flushSeq) begin
      w_opBubbleNext = 1'b1;
    end else begin
      case (r_state)
        c_stIssue: begin
          if (r_intPend) begin
            w_opCodeNext  = c_opIntA;
            w_opValidNext = 1'b1;
          end else if (fetch_valid) begin
            w_opCodeNext  = w_fetchOp;
            w_opValidNext = 1'b1;
            if (w_isPair) begin
              w_secondOpNext = w_fetchOp | 5'b00001;
            end
          end
        end
        c_stSecond: begin
          w_opCodeNext  = r_secondOp;
          w_opValidNext = 1'b1;
        end
        c_stImm: begin
          if (fetch_valid) begin
            w_immValidNext = 1'b1;
            w_immDataNext  = fetch_word;
          end
        end
        c_stInt1: begin
          w_opCodeNext  = c_opIntB;
          w_opValidNext = 1'b1;
          w_intAckNext  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign op_code   = r_opCode;
  assign op_valid  = r_opValid;
  assign op_bubble = r_opBubble;
  assign imm_valid = r_immValid;
  assign imm_data  = r_immData;
  assign int_ack   = r_intAck;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_instr_sequencer: directed vector table plus reset-mid-sequence case. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_instr_sequencer;

  localparam int IW = 16;

  logic          clk;
  logic          rst_n;
  logic          fetch_valid;
  logic [IW-1:0] fetch_word;
  logic          fetch_ready;
  logic          stall;
  logic          flush;
  logic          int_req;
  logic [4:0]    op_code;
  logic          op_valid;
  logic          op_bubble;
  logic          imm_valid;
  logic [IW-1:0] imm_data;
  logic          int_ack;

  int nCompared;
  int nMismatched;

  instr_sequencer #(.IW(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_valid(fetch_valid),
    .fetch_word (fetch_word),
    .fetch_ready(fetch_ready),
    .stall      (stall),
    .flush      (flush),
    .int_req    (int_req),
    .op_code    (op_code),
    .op_valid   (op_valid),
    .op_bubble  (op_bubble),
    .imm_valid  (imm_valid),
    .imm_data   (imm_data),
    .int_ack    (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [15:0] word;
    logic        st;
    logic        fl;
    logic        ir;
    logic        rdy;
    logic [4:0]  op;
    logic        v;
    logic        b;
    logic        iv;
    logic [15:0] id;
    logic        ack;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fv, input logic [15:0] word, input logic st,
                              input logic fl, input logic ir, input logic rdy,
                              input logic [4:0] op, input logic v, input logic b,
                              input logic iv, input logic [15:0] id, input logic ack);
    vec_t t;
    t.fv = fv; t.word = word; t.st = st; t.fl = fl; t.ir = ir; t.rdy = rdy;
    t.op = op; t.v = v; t.b = b; t.iv = iv; t.id = id; t.ack = ack;
    return t;
  endfunction

  function automatic logic [15:0] w(input logic [4:0] op);
    return {op, 11'h2A5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input int idx);
    @(negedge clk);
    fetch_valid = t.fv;
    fetch_word  = t.word;
    stall       = t.st;
    flush       = t.fl;
    int_req     = t.ir;
    #1;
    chk($sformatf("row%0d fetch_ready", idx), 32'(fetch_ready), 32'(t.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("row%0d op_code", idx), 32'(op_code), 32'(t.op));
    chk($sformatf("row%0d op_valid", idx), 32'(op_valid), 32'(t.v));
    chk($sformatf("row%0d op_bubble", idx), 32'(op_bubble), 32'(t.b));
    chk($sformatf("row%0d imm_valid", idx), 32'(imm_valid), 32'(t.iv));
    chk($sformatf("row%0d imm_data", idx), 32'(imm_data), 32'(t.id));
    chk($sformatf("row%0d int_ack", idx), 32'(int_ack), 32'(t.ack));
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n       = 1'b0;
    fetch_valid = 1'b0;
    fetch_word  = '0;
    stall       = 1'b0;
    flush       = 1'b0;
    int_req     = 1'b0;

    //            fv  word           st  fl  ir | rdy op        v  b  iv id        ack
    vecs.push_back(mk(1, w(5'b01001), 0, 0, 0,   1, 5'b01001, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, w(5'b00011), 0, 0, 0,   1, 5'b00011, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, w(5'b00100), 0, 0, 0,   1, 5'b00000, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, w(5'b11000), 0, 0, 0,   1, 5'b11000, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, w(5'b00101), 0, 0, 0,   0, 5'b11001, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, w(5'b00101), 0, 0, 0,   1, 5'b00101, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, w(5'b10001), 0, 0, 0,   1, 5'b10001, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 16'h0000,    0, 0, 0,   1, 5'b00000, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 16'hBEEF,    0, 0, 0,   1, 5'b00000, 0, 0, 1, 16'hBEEF, 0));
    vecs.push_back(mk(0, 16'h0000,    0, 0, 0,   1, 5'b00000, 0, 0, 0, 16'hBEEF, 0));
    // RET with a one-cycle interrupt pulse
    vecs.push_back(mk(1, w(5'b11010), 0, 0, 1,   1, 5'b11010, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b01111), 0, 0, 0,   0, 5'b11011, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b01111), 0, 0, 0,   0, 5'b11110, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b01111), 0, 0, 0,   0, 5'b11111, 1, 0, 0, 16'hBEEF, 1));
    vecs.push_back(mk(1, w(5'b01111), 0, 0, 0,   0, 5'b00000, 0, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b01111), 0, 0, 0,   1, 5'b01111, 1, 0, 0, 16'hBEEF, 0));
    // RTI flushed in its second slot, then flush in ISSUE
    vecs.push_back(mk(1, w(5'b11100), 0, 0, 0,   1, 5'b11100, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00001), 0, 1, 0,   0, 5'b00000, 0, 1, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00001), 0, 0, 0,   1, 5'b00001, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00010), 0, 1, 0,   0, 5'b00000, 0, 1, 0, 16'hBEEF, 0));
    // Stall held 3 cycles mid-CALL
    vecs.push_back(mk(1, w(5'b11000), 0, 0, 0,   1, 5'b11000, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00110), 1, 0, 0,   0, 5'b11000, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00110), 1, 0, 0,   0, 5'b11000, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00110), 1, 0, 0,   0, 5'b11000, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00110), 0, 0, 0,   0, 5'b11001, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00110), 0, 0, 0,   1, 5'b00110, 1, 0, 0, 16'hBEEF, 0));
    // int_req with CALL accept, flush during INT1 and INT2 ignored
    vecs.push_back(mk(1, w(5'b11000), 0, 0, 1,   1, 5'b11000, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00111), 0, 0, 0,   0, 5'b11001, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00111), 0, 0, 0,   0, 5'b11110, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00111), 0, 1, 0,   0, 5'b11111, 1, 0, 0, 16'hBEEF, 1));
    vecs.push_back(mk(1, w(5'b00111), 0, 1, 0,   0, 5'b00000, 0, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00111), 0, 0, 0,   1, 5'b00111, 1, 0, 0, 16'hBEEF, 0));
    // Flush in IMM discards the immediate
    vecs.push_back(mk(1, w(5'b10001), 0, 0, 0,   1, 5'b10001, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, 16'h1234,    0, 1, 0,   0, 5'b00000, 0, 1, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00001), 0, 0, 0,   1, 5'b00001, 1, 0, 0, 16'hBEEF, 0));
    // int_req latched while stalled
    vecs.push_back(mk(1, w(5'b00010), 1, 0, 1,   0, 5'b00001, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00010), 0, 0, 0,   0, 5'b11110, 1, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(1, w(5'b00010), 0, 0, 0,   0, 5'b11111, 1, 0, 0, 16'hBEEF, 1));
    vecs.push_back(mk(1, w(5'b00010), 0, 0, 0,   0, 5'b00000, 0, 0, 0, 16'hBEEF, 0));
    vecs.push_back(mk(0, w(5'b00010), 0, 0, 0,   1, 5'b00000, 0, 0, 0, 16'hBEEF, 0));

    #12;
    chk("reset op_code", 32'(op_code), 32'h0);
    chk("reset op_valid", 32'(op_valid), 32'h0);
    chk("reset op_bubble", 32'(op_bubble), 32'h0);
    chk("reset imm_valid", 32'(imm_valid), 32'h0);
    chk("reset imm_data", 32'(imm_data), 32'h0);
    chk("reset int_ack", 32'(int_ack), 32'h0);
    chk("reset fetch_ready", 32'(fetch_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Reset mid-CALL with an interrupt pending: everything abandoned at once.
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_word  = w(5'b11000);
    int_req     = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset call issued", 32'(op_code), 32'(5'b11000));
    int_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset op_code", 32'(op_code), 32'h0);
    chk("midreset op_valid", 32'(op_valid), 32'h0);
    chk("midreset imm_data", 32'(imm_data), 32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    fetch_word  = w(5'b01010);
    #1;
    chk("midreset fetch_ready", 32'(fetch_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("midreset next op", 32'(op_code), 32'(5'b01010));
    chk("midreset next valid", 32'(op_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
